prbs7_capture_checker: RTL and testbench
========================================

Name: prbs7_capture_checker

Overview:
- Capture-side companion to the launch-flop driver used in the resizer buffer-insertion test designs.
- Receives a serial PRBS7 stream (x^7+x^6+1) from a launch flop through a buffered, possibly hierarchical net, self-synchronises to it, and reports lock and bit errors.
- Sits at the load end of the net under test, so timing repair can be checked functionally in simulation.

Parameters:
LOCK_CNT, 16, consecutive matching valid bits in VERIFY required to declare lock (1..255)
LOSS_THRESH, 4, consecutive mismatching valid bits in LOCKED that drop lock (1..15)
CNT_W, 16, width of the saturating error counter and the bit counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
din  input  1  serial data bit; sampled only when din_valid=1
din_valid  input  1  qualifies din for the current cycle
clr_cnt  input  1  synchronous clear of err_count and bit_count; lock state unaffected
locked  output  1  checker is in LOCKED
err_pulse  output  1  one-cycle pulse: the previous valid bit mismatched while LOCKED
err_count  output  CNT_W  saturating count of mismatches seen while LOCKED
bit_count  output  CNT_W  saturating count of valid bits checked while LOCKED (feature-dependent)

Behaviour:
- One clock and one reset: clk; rst is synchronous and active-high. No other clocks. No asynchronous logic.
- Reset values: state=SEED, sreg=7'h00, seed_cnt=0, match_cnt=0, consec_err=0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- Internal 7-bit shift register sreg. Predicted bit pred = sreg[6]^sreg[5].
- A cycle with din_valid=0 changes no state. err_pulse is 0 in such a cycle.
- SEED:
  - On each valid bit: sreg <= {sreg[5:0], din}; seed_cnt increments, saturating at 7.
  - Once seed_cnt=7 and the updated sreg is nonzero, go to VERIFY with match_cnt=0.
  - An all-zero sreg stays in SEED and keeps sliding in bits. All-zero is the lock-up state and is never accepted.
- VERIFY:
  - On each valid bit: sreg <= {sreg[5:0], din} (self-synchronising).
  - If din==pred, match_cnt++.
  - If din!=pred, return to SEED with seed_cnt=0 and match_cnt=0. sreg keeps the shifted value.
  - When match_cnt reaches LOCK_CNT, go to LOCKED. locked=1 from the next cycle.
  - An ideal stream asserts locked in the cycle after the (7+LOCK_CNT)th valid bit.
- LOCKED:
  - On each valid bit: sreg <= {sreg[5:0], pred}. The generator free-runs, so errors do not propagate.
  - Mismatch: err_pulse=1 next cycle; err_count++ (saturating at 2^CNT_W-1); consec_err++.
  - Match: consec_err=0.
  - When consec_err reaches LOSS_THRESH, go to SEED with seed_cnt=0 and locked=0 next cycle. The err_pulse for that bit still fires. err_count is kept.
- Counter priority: clr_cnt wins over a same-cycle increment, so the counters read 0 next cycle.
- Counters are not cleared on loss of lock. Only rst or clr_cnt clears them.
- rst asserted mid-stream, in any state, returns everything to reset values on the next edge.

Optional Feature:
PRBS7_CHK_BITCNT_EN
- Defined: bit_count increments (saturating) on every valid bit checked in LOCKED and is cleared by rst or clr_cnt. This gives the BER denominator.
- Undefined: bit_count is tied to 0 and no counter flops are inferred. The port is always present.

Test Plan:
- Ideal PRBS7 stream (generator seeded 7'h01), din_valid=1 every cycle, LOCK_CNT=16 -> locked rises in the cycle after the 23rd bit; err_count=0 and err_pulse=0 after 200 bits.
- Lock, then flip one bit at valid bit 100 -> exactly one err_pulse, one cycle after that bit; err_count=1; locked stays 1; the following bits match.
- Lock, then flip 4 consecutive bits (LOSS_THRESH=4) -> err_count=4; locked falls the cycle after the 4th bad bit; relock after 23 further clean bits, with err_count still 4.
- All-zero din for 50 valid bits -> state stays SEED, locked=0 throughout; then an ideal stream -> locks after 23 bits.
- Ideal stream with din_valid toggling 1,0,1,0 -> lock timing counted in valid bits only (46 cycles); bits presented with din_valid=0 are ignored.
- With PRBS7_CHK_BITCNT_EN: lock, 1000 valid bits, then clr_cnt pulse with a simultaneous error -> bit_count=1000 before the pulse; err_count=0 and bit_count=0 after it. Rst mid-lock -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/prbs7_capture_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) capture checker: seeds from the stream, verifies, locks, counts bit errors.
// Optional bit counter for the BER denominator is enabled by defining PRBS7_CHK_BITCNT_EN.
module prbs7_capture_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [6:0]       sreg_q, sreg_d;
    logic [2:0]       seed_cnt_q, seed_cnt_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       consec_err_q, consec_err_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic       pred;
    logic       mismatch;
    logic [6:0] shifted;
    logic       locked_err;

    assign pred       = sreg_q[6] ^ sreg_q[5];
    assign mismatch   = din ^ pred;
    assign shifted    = {sreg_q[5:0], din};
    assign locked_err = din_valid && (state_q == LOCKED) && mismatch;

    // Once locked the register is fed from its own prediction, so a corrupted bit never poisons later predictions.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        seed_cnt_d   = seed_cnt_q;
        match_cnt_d  = match_cnt_q;
        consec_err_d = consec_err_q;
        err_pulse_d  = 1'b0;
        if (din_valid) begin
            case (state_q)
                SEED: begin
                    sreg_d = shifted;
                    if (seed_cnt_q != 3'd7) begin
                        seed_cnt_d = seed_cnt_q + 3'd1;
                    end
                    if ((seed_cnt_q >= 3'd6) && (shifted != 7'h00)) begin
                        state_d     = VERIFY;
                        match_cnt_d = 8'd0;
                    end
                end
                VERIFY: begin
                    sreg_d = shifted;
                    if (mismatch) begin
                        state_d     = SEED;
                        seed_cnt_d  = 3'd0;
                        match_cnt_d = 8'd0;
                    end else if (match_cnt_q == 8'(LOCK_CNT - 1)) begin
                        state_d      = LOCKED;
                        match_cnt_d  = 8'd0;
                        consec_err_d = 4'd0;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end
                LOCKED: begin
                    sreg_d = {sreg_q[5:0], pred};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (consec_err_q == 4'(LOSS_THRESH - 1)) begin
                            state_d      = SEED;
                            seed_cnt_d   = 3'd0;
                            consec_err_d = 4'd0;
                        end else begin
                            consec_err_d = consec_err_q + 4'd1;
                        end
                    end else begin
                        consec_err_d = 4'd0;
                    end
                end
                default: begin
                    state_d    = SEED;
                    seed_cnt_d = 3'd0;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (locked_err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEED;
            sreg_q       <= 7'h00;
            seed_cnt_q   <= 3'd0;
            match_cnt_q  <= 8'd0;
            consec_err_q <= 4'd0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            seed_cnt_q   <= seed_cnt_d;
            match_cnt_q  <= match_cnt_d;
            consec_err_q <= consec_err_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

`ifdef PRBS7_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // Every valid bit checked while locked, matching or not, so err_count/bit_count is the BER.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (clr_cnt) begin
            bit_cnt_d = '0;
        end else if (din_valid && (state_q == LOCKED) && (bit_cnt_q != CNT_MAX)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_count = bit_cnt_q;
`else
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_prbs7_capture_checker.sv
// Scoreboard bench for prbs7_capture_checker: the driver queues per-cycle expectations, a monitor pops and compares.
// Bit-count expectations follow PRBS7_CHK_BITCNT_EN when the bench is built with it.
module tb_prbs7_capture_checker;

`ifdef PRBS7_CHK_BITCNT_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        din;
    logic        dinValid;
    logic        clrCnt;
    logic        locked;
    logic        errPulse;
    logic [15:0] errCount;
    logic [15:0] bitCount;

    typedef struct {
        int          tid;
        int          step;
        logic [3:0]  mask;
        logic        eLocked;
        logic        ePulse;
        logic [15:0] eErr;
        logic [15:0] eBit;
    } exp_t;

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   curTid   = 0;
    int   stepNo   = 0;
    logic [6:0] g;

    prbs7_capture_checker #(
        .LOCK_CNT(16),
        .LOSS_THRESH(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(dinValid),
        .clr_cnt(clrCnt),
        .locked(locked),
        .err_pulse(errPulse),
        .err_count(errCount),
        .bit_count(bitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bitExp(input int n);
        if (BC && n > 0) return 16'(n);
        return 16'd0;
    endfunction

    // Reference generator emits its oldest register bit, so the seed itself is the first 7 bits of the stream.
    task automatic nextBit(output logic b);
        b = g[6];
        g = {g[5:0], g[6] ^ g[5]};
    endtask

    task automatic applyStimulus(input logic d, input logic v, input logic c, input logic r,
                                 input logic [3:0] m, input logic el, input logic ep,
                                 input logic [15:0] ee, input logic [15:0] eb);
        exp_t e;
        @(negedge clk);
        din      = d;
        dinValid = v;
        clrCnt   = c;
        rst      = r;
        e.tid = curTid; e.step = stepNo; e.mask = m;
        e.eLocked = el; e.ePulse = ep; e.eErr = ee; e.eBit = eb;
        sbQ.push_back(e);
        stepNo++;
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.mask[0]) begin
            checks++;
            if (locked !== e.eLocked) begin
                failures++;
                $display("[TB] FAIL locked t%0d s%0d got=%b want=%b", e.tid, e.step, locked, e.eLocked);
            end
        end
        if (e.mask[1]) begin
            checks++;
            if (errPulse !== e.ePulse) begin
                failures++;
                $display("[TB] FAIL err_pulse t%0d s%0d got=%b want=%b", e.tid, e.step, errPulse, e.ePulse);
            end
        end
        if (e.mask[2]) begin
            checks++;
            if (errCount !== e.eErr) begin
                failures++;
                $display("[TB] FAIL err_count t%0d s%0d got=%0d want=%0d", e.tid, e.step, errCount, e.eErr);
            end
        end
        if (e.mask[3]) begin
            checks++;
            if (bitCount !== e.eBit) begin
                failures++;
                $display("[TB] FAIL bit_count t%0d s%0d got=%0d want=%0d", e.tid, e.step, bitCount, e.eBit);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sbQ.size() > 0) begin
            checkOutput(sbQ.pop_front());
        end
    end

    task automatic resetCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 16'd0, 16'd0);
        curTid++;
        stepNo = 0;
    endtask

    initial begin
        logic b;
        logic f;
        int   vcount;
        logic [15:0] ee;
        int   n;
        rst = 1'b1; din = 1'b0; dinValid = 1'b0; clrCnt = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 16'd0, 16'd0);
        resetCycle();

        // Ideal stream: lock after the 23rd bit, no errors over 200 bits, then reset while locked.
        g = 7'h01;
        for (int i = 1; i <= 200; i++) begin
            nextBit(b);
            applyStimulus(b, 1'b1, 1'b0, 1'b0, 4'hF, i >= 23, 1'b0, 16'd0, bitExp(i - 23));
        end
        nextBit(b);
        applyStimulus(~b, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 16'd0, 16'd0);
        curTid++; stepNo = 0;

        // Single flipped bit at valid bit 100.
        g = 7'h01;
        for (int i = 1; i <= 130; i++) begin
            nextBit(b);
            f = (i == 100);
            applyStimulus(b ^ f, 1'b1, 1'b0, 1'b0, 4'hF, i >= 23, f, (i >= 100) ? 16'd1 : 16'd0, bitExp(i - 23));
        end
        resetCycle();

        // Four consecutive bad bits drop lock; 23 clean bits relock with err_count held.
        g = 7'h01;
        for (int i = 1; i <= 100; i++) begin
            nextBit(b);
            f  = (i >= 50 && i <= 53);
            ee = (i < 50) ? 16'd0 : ((i > 53) ? 16'd4 : 16'(i - 49));
            n  = (i <= 53) ? (i - 23) : ((i <= 76) ? 30 : (30 + i - 76));
            applyStimulus(b ^ f, 1'b1, 1'b0, 1'b0, 4'hF, (i >= 23 && i < 53) || (i >= 76), f, ee, bitExp(n));
        end
        resetCycle();

        // All-zero lock-up pattern is never accepted; a real stream afterwards still locks in 23 bits.
        for (int i = 1; i <= 50; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 16'd0, 16'd0);
        end
        g = 7'h01;
        for (int j = 1; j <= 30; j++) begin
            nextBit(b);
            applyStimulus(b, 1'b1, 1'b0, 1'b0, 4'hF, j >= 23, 1'b0, 16'd0, bitExp(j - 23));
        end
        resetCycle();

        // Alternating valid: invalid cycles carry the wrong bit and must be ignored.
        g = 7'h01;
        vcount = 0;
        for (int c = 0; c < 60; c++) begin
            if (c % 2 == 0) begin
                nextBit(b);
                vcount++;
                applyStimulus(b, 1'b1, 1'b0, 1'b0, 4'hF, vcount >= 23, 1'b0, 16'd0, bitExp(vcount - 23));
            end else begin
                applyStimulus(~g[6], 1'b0, 1'b0, 1'b0, 4'hF, vcount >= 23, 1'b0, 16'd0, bitExp(vcount - 23));
            end
        end
        resetCycle();

        // 1000 locked bits, then clr_cnt together with an error, then reset mid-lock.
        g = 7'h01;
        for (int i = 1; i <= 1023; i++) begin
            nextBit(b);
            f = (i == 500);
            applyStimulus(b ^ f, 1'b1, 1'b0, 1'b0, 4'hF, i >= 23, f, (i >= 500) ? 16'd1 : 16'd0, bitExp(i - 23));
        end
        nextBit(b);
        applyStimulus(~b, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 16'd0, 16'd0);
        nextBit(b);
        applyStimulus(b, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 16'd0, bitExp(1));
        nextBit(b);
        applyStimulus(b, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 16'd0, bitExp(2));
        resetCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 16'd0, 16'd0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
